qpsk_sync_detect: RTL and testbench
===================================

# qpsk_sync_detect

Symbol-level frame synchronizer between the QPSK demodulator/slicer and the symbol-to-word collector. It hunts a 2-bit symbol stream for a 32-bit sync word, with optional bit-error tolerance. It then forwards exactly one frame of payload symbols with start/end markers, so the downstream collector packs words on a known boundary. Symbols outside a frame are discarded.

## Interface
Parameters:
- SYNC_WORD, 32'hA5F0_3C96, sync pattern as it appears in the 32-bit window after 16 symbols.
- SYNC_ERR_MAX, 0, maximum number of differing bits (0..31) still counted as a match.
- PAYLOAD_SYMS, 256, payload symbols per frame; multiple of 16, range 16..65535.
- GAP_TIMEOUT, 1023, idle cycles without valid_i tolerated inside a frame; range 1..65535.

Ports:
- CLK  in  1  clock; all logic on rising edge.
- RST  in  1  synchronous, active-high reset.
- valid_i  in  1  data_i carries a symbol this cycle.
- data_i  in  2  QPSK symbol.
- valid_o  out  1  payload symbol on data_o.
- data_o  out  2  forwarded payload symbol.
- sof_o  out  1  qualifies the first payload symbol; coincident with valid_o.
- eof_o  out  1  qualifies the last payload symbol; coincident with valid_o.
- locked_o  out  1  high while in PAYLOAD.
- abort_o  out  1  one-cycle pulse when a frame is dropped on gap timeout.
- frame_cnt_o  out  16  count of completed frames; wraps 16'hFFFF -> 0.

## Operation
- Window: 32-bit shift register, updated only on valid_i: window <= {data_i, window[31:2]}. The newest symbol enters at bits [31:30].
- Fill counter (0..16, saturating): counts symbols since entering HUNT. A match is only legal once the window holds 16 fresh symbols, i.e. the current symbol is at least the 16th.
- Match: popcount({data_i, window[31:2]} XOR SYNC_WORD) <= SYNC_ERR_MAX. Evaluated combinationally on the incoming symbol.
- FSM states:
  - HUNT: on valid_i with match and fill >= 15, go to PAYLOAD with sym_cnt = 0 and gap_cnt = 0. The sync symbols themselves are never forwarded.
  - PAYLOAD, per valid_i: forward the symbol, increment sym_cnt, clear gap_cnt. The symbol with sym_cnt == 0 carries sof_o. The symbol with sym_cnt == PAYLOAD_SYMS-1 carries eof_o; then go to HUNT, clear the window and fill counter, and increment frame_cnt_o.
  - PAYLOAD without valid_i: increment gap_cnt. When gap_cnt reaches GAP_TIMEOUT, pulse abort_o and go to HUNT, clearing the window and fill counter. No eof_o is issued.
- Simultaneous events:
  - valid_i in the cycle the timeout would fire: the symbol is accepted and there is no abort.
  - Sync pattern appearing inside the payload: ignored, no re-sync.
- Reset mid-frame: everything returns to reset values next cycle, with no eof_o or abort_o.
- Reset values: all outputs 0, window 0, fill 0, sym_cnt 0, gap_cnt 0, state HUNT.

## Timing
- Latency is 1 cycle from valid_i/data_i to valid_o/data_o; all outputs are registered.
- locked_o rises the cycle after the matching symbol is accepted.
- locked_o falls in the same cycle eof_o or abort_o is asserted.
- First payload symbol: arrives on valid_i at cycle t (t after the match cycle) and appears on valid_o with sof_o at t+1.
- frame_cnt_o updates in the same cycle eof_o is high.
- No backpressure: the downstream stage accepts every valid_o.
- Consecutive frames: a new sync needs 16 fresh symbols after eof, so the earliest next sof is 17 symbols after eof.

## Test plan
- Clean frame: random noise, then SYNC_WORD symbols, then 256 payload symbols 0,1,2,3,…. Expect:
  - valid_o exactly 256 times, with data_o matching the payload.
  - sof_o on the first, eof_o on the last.
  - locked_o high for the span; frame_cnt_o = 1.
- Fill guard: reset, then feed exactly 15 symbols that are SYNC_WORD's top 30 bits. Expect no lock. The 16th symbol completing the pattern locks.
- Error tolerance: with SYNC_ERR_MAX=2, a sync word with 2 flipped bits locks. With 3 flipped bits it stays in HUNT with no valid_o.
- Gap timeout: with GAP_TIMEOUT=8, stop valid_i after 10 payload symbols. Expect:
  - abort_o pulses exactly 8 idle cycles later; locked_o goes to 0.
  - No eof_o; frame_cnt_o unchanged.
  - Repeat with valid_i on the 8th idle cycle: no abort.
- Back-to-back frames: two frames separated by a sync only. Expect two sof/eof pairs and frame_cnt_o = 2. A sync pattern embedded in the payload causes no re-sync.
- Mid-frame reset: assert RST for 1 cycle after 100 payload symbols. Expect:
  - All outputs 0 next cycle; no eof_o.
  - frame_cnt_o = 0; a following full frame is received normally.

Source files
------------

// File: rtl/qpsk_sync_detect.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | qpsk_sync_detect: hunts a 2-bit symbol stream for a 32-bit sync word and   |
// | forwards one framed payload of symbols with sof/eof markers.               |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module qpsk_sync_detect #(
  parameter logic [31:0] SYNC_WORD    = 32'hA5F0_3C96,
  parameter int unsigned SYNC_ERR_MAX = 0,
  parameter int unsigned PAYLOAD_SYMS = 256,
  parameter int unsigned GAP_TIMEOUT  = 1023
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        valid_i,
  input  logic [1:0]  data_i,
  output logic        valid_o,
  output logic [1:0]  data_o,
  output logic        sof_o,
  output logic        eof_o,
  output logic        locked_o,
  output logic        abort_o,
  output logic [15:0] frame_cnt_o
);

  localparam logic [5:0]  ERR_MAX  = 6'(SYNC_ERR_MAX);
  localparam logic [15:0] LAST_SYM = 16'(PAYLOAD_SYMS - 1);
  localparam logic [15:0] GAP_LAST = 16'(GAP_TIMEOUT - 1);
  localparam logic [4:0]  FILL_MAX = 5'd16;
  localparam logic [4:0]  FILL_MIN = 5'd15;

  typedef enum logic [0:0] {
    HUNT    = 1'b0,
    PAYLOAD = 1'b1
  } state_t;

  state_t      state;
  state_t      state_nx;
  logic [31:0] window;
  logic [31:0] window_nx;
  logic [31:0] cand;
  logic [31:0] diff;
  logic [5:0]  err_cnt;
  logic        match;
  logic [4:0]  fill;
  logic [4:0]  fill_nx;
  logic [15:0] sym_cnt;
  logic [15:0] sym_cnt_nx;
  logic [15:0] gap_cnt;
  logic [15:0] gap_cnt_nx;
  logic [15:0] frame_cnt_nx;
  logic        valid_nx;
  logic [1:0]  data_nx;
  logic        sof_nx;
  logic        eof_nx;
  logic        abort_nx;
  logic        locked_nx;

  // Match is judged on the window as it would look with the incoming symbol.
  always_comb begin
    cand    = {data_i, window[31:2]};
    diff    = cand ^ SYNC_WORD;
    err_cnt = '0;
    for (int i = 0; i < 32; i++) begin
      err_cnt = err_cnt + {5'd0, diff[i]};
    end
    match = (err_cnt <= ERR_MAX) && (fill >= FILL_MIN);
  end

  always_comb begin
    state_nx     = state;
    window_nx    = window;
    fill_nx      = fill;
    sym_cnt_nx   = sym_cnt;
    gap_cnt_nx   = gap_cnt;
    frame_cnt_nx = frame_cnt_o;
    valid_nx     = 1'b0;
    data_nx      = 2'b00;
    sof_nx       = 1'b0;
    eof_nx       = 1'b0;
    abort_nx     = 1'b0;

    case (state)
      HUNT: begin
        if (valid_i) begin
          window_nx = cand;
          fill_nx   = (fill == FILL_MAX) ? FILL_MAX : fill + 5'd1;
          if (match) begin
            state_nx   = PAYLOAD;
            sym_cnt_nx = '0;
            gap_cnt_nx = '0;
          end
        end
      end

      PAYLOAD: begin
        if (valid_i) begin
          valid_nx   = 1'b1;
          data_nx    = data_i;
          sof_nx     = (sym_cnt == 16'd0);
          eof_nx     = (sym_cnt == LAST_SYM);
          sym_cnt_nx = sym_cnt + 16'd1;
          gap_cnt_nx = '0;
          if (sym_cnt == LAST_SYM) begin
            state_nx     = HUNT;
            window_nx    = '0;
            fill_nx      = '0;
            frame_cnt_nx = frame_cnt_o + 16'd1;
          end
        end else if (gap_cnt == GAP_LAST) begin
          // A symbol arriving in this cycle takes the branch above instead.
          abort_nx   = 1'b1;
          state_nx   = HUNT;
          window_nx  = '0;
          fill_nx    = '0;
          gap_cnt_nx = '0;
        end else begin
          gap_cnt_nx = gap_cnt + 16'd1;
        end
      end

      default: begin
        state_nx = HUNT;
      end
    endcase

    locked_nx = (state_nx == PAYLOAD);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= HUNT;
    end else begin
      state <= state_nx;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      window      <= '0;
      fill        <= '0;
      sym_cnt     <= '0;
      gap_cnt     <= '0;
      frame_cnt_o <= '0;
      valid_o     <= 1'b0;
      data_o      <= 2'b00;
      sof_o       <= 1'b0;
      eof_o       <= 1'b0;
      abort_o     <= 1'b0;
      locked_o    <= 1'b0;
    end else begin
      window      <= window_nx;
      fill        <= fill_nx;
      sym_cnt     <= sym_cnt_nx;
      gap_cnt     <= gap_cnt_nx;
      frame_cnt_o <= frame_cnt_nx;
      valid_o     <= valid_nx;
      data_o      <= data_nx;
      sof_o       <= sof_nx;
      eof_o       <= eof_nx;
      abort_o     <= abort_nx;
      locked_o    <= locked_nx;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_qpsk_sync_detect.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_qpsk_sync_detect: directed stimulus with a queue-based output scoreboard|
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_qpsk_sync_detect;

  localparam logic [31:0] SW  = 32'hA5F0_3C96;
  localparam int          ERR = 2;
  localparam int          PAY = 256;
  localparam int          GAP = 8;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        valid_i = 1'b0;
  logic [1:0]  data_i = 2'b00;
  logic        valid_o;
  logic [1:0]  data_o;
  logic        sof_o;
  logic        eof_o;
  logic        locked_o;
  logic        abort_o;
  logic [15:0] frame_cnt_o;

  typedef struct packed {
    logic [1:0]  d;
    logic        sof;
    logic        eof;
    logic        lk;
    logic [15:0] fc;
  } exp_t;

  exp_t        q[$];
  logic [15:0] abq[$];
  int          checks = 0;
  int          errors = 0;

  qpsk_sync_detect #(
    .SYNC_WORD    (SW),
    .SYNC_ERR_MAX (ERR),
    .PAYLOAD_SYMS (PAY),
    .GAP_TIMEOUT  (GAP)
  ) dut (
    .CLK         (CLK),
    .RST         (RST),
    .valid_i     (valid_i),
    .data_i      (data_i),
    .valid_o     (valid_o),
    .data_o      (data_o),
    .sof_o       (sof_o),
    .eof_o       (eof_o),
    .locked_o    (locked_o),
    .abort_o     (abort_o),
    .frame_cnt_o (frame_cnt_o)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, expv, $time);
    end
  endtask

  // Scoreboard monitor: every presented output is matched against the queue.
  always @(negedge CLK) begin
    exp_t        e;
    logic [15:0] fa;
    if (valid_o) begin
      if (q.size() == 0) begin
        chk("stray_valid", {31'd0, valid_o}, 32'd0);
      end else begin
        e = q.pop_front();
        chk("data",      {30'd0, data_o},   {30'd0, e.d});
        chk("sof",       {31'd0, sof_o},    {31'd0, e.sof});
        chk("eof",       {31'd0, eof_o},    {31'd0, e.eof});
        chk("locked",    {31'd0, locked_o}, {31'd0, e.lk});
        chk("frame_cnt", {16'd0, frame_cnt_o}, {16'd0, e.fc});
      end
    end else if (sof_o || eof_o) begin
      chk("marker_without_valid", {30'd0, sof_o, eof_o}, 32'd0);
    end
    if (abort_o) begin
      if (abq.size() == 0) begin
        chk("stray_abort", {31'd0, abort_o}, 32'd0);
      end else begin
        fa = abq.pop_front();
        chk("abort_locked",    {31'd0, locked_o}, 32'd0);
        chk("abort_eof",       {31'd0, eof_o},    32'd0);
        chk("abort_frame_cnt", {16'd0, frame_cnt_o}, {16'd0, fa});
      end
    end
  end

  task automatic send(input logic [1:0] s);
    @(negedge CLK);
    valid_i = 1'b1;
    data_i  = s;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge CLK);
      valid_i = 1'b0;
      data_i  = 2'b00;
    end
  endtask

  task automatic settle();
    @(posedge CLK);
    #1;
  endtask

  task automatic noise(input int n);
    for (int i = 0; i < n; i++) send(2'((i * 3 + 1) % 4));
  endtask

  task automatic send_sync(input logic [31:0] pat);
    for (int k = 0; k < 16; k++) send(pat[2*k +: 2]);
  endtask

  function automatic logic [1:0] psym(input int i, input bit embed);
    logic [31:0] w;
    w = SW;
    if (embed && i >= 100 && i < 116) return w[2*(i-100) +: 2];
    return 2'(i);
  endfunction

  // fc_eof is the frame count expected on the eof symbol; earlier symbols see one less.
  task automatic payload(input int from, input int to, input bit embed, input logic [15:0] fc_eof);
    exp_t e;
    for (int i = from; i < to; i++) begin
      e.d   = psym(i, embed);
      e.sof = (i == 0);
      e.eof = (i == PAY - 1);
      e.lk  = !e.eof;
      e.fc  = e.eof ? fc_eof : fc_eof - 16'd1;
      q.push_back(e);
      send(e.d);
    end
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_valid"},  {31'd0, valid_o},  32'd0);
    chk({nm, "_data"},   {30'd0, data_o},   32'd0);
    chk({nm, "_sofeof"}, {30'd0, sof_o, eof_o}, 32'd0);
    chk({nm, "_locked"}, {31'd0, locked_o}, 32'd0);
    chk({nm, "_abort"},  {31'd0, abort_o},  32'd0);
    chk({nm, "_fcnt"},   {16'd0, frame_cnt_o}, 32'd0);
  endtask

  task automatic pulse_reset();
    @(negedge CLK);
    RST     = 1'b1;
    valid_i = 1'b0;
    @(negedge CLK);
    RST = 1'b0;
  endtask

  initial begin
    logic [31:0] w;
    w = SW;
    repeat (3) @(negedge CLK);
    chk_zero("reset");
    RST = 1'b0;

    // Fill guard: 15 symbols give a 1-bit-off window, still too early to lock.
    for (int k = 1; k < 16; k++) send(w[2*k +: 2]);
    settle();
    chk("guard15_locked", {31'd0, locked_o}, 32'd0);
    pulse_reset();
    for (int k = 0; k < 15; k++) send(w[2*k +: 2]);
    settle();
    chk("guard15b_locked", {31'd0, locked_o}, 32'd0);
    send(w[31:30]);
    settle();
    chk("guard16_locked", {31'd0, locked_o}, 32'd1);
    pulse_reset();
    chk_zero("reset2");

    // Clean frame.
    noise(20);
    send_sync(SW);
    settle();
    chk("clean_lock", {31'd0, locked_o}, 32'd1);
    payload(0, PAY, 1'b0, 16'd1);
    idle(2);
    chk("clean_fcnt", {16'd0, frame_cnt_o}, 32'd1);
    chk("clean_unlock", {31'd0, locked_o}, 32'd0);

    // Error tolerance: two flipped bits lock, three do not.
    noise(5);
    send_sync(SW ^ 32'h0000_0101);
    settle();
    chk("err2_lock", {31'd0, locked_o}, 32'd1);
    payload(0, PAY, 1'b0, 16'd2);
    noise(5);
    send_sync(SW ^ 32'h8000_0101);
    settle();
    chk("err3_nolock", {31'd0, locked_o}, 32'd0);
    noise(6);

    // Gap timeout.
    send_sync(SW);
    payload(0, 10, 1'b0, 16'd3);
    idle(7);
    settle();
    chk("gap7_abort", {31'd0, abort_o}, 32'd0);
    chk("gap7_locked", {31'd0, locked_o}, 32'd1);
    abq.push_back(16'd2);
    idle(1);
    settle();
    chk("gap8_abort", {31'd0, abort_o}, 32'd1);
    chk("gap8_locked", {31'd0, locked_o}, 32'd0);
    chk("gap8_fcnt", {16'd0, frame_cnt_o}, 32'd2);
    settle();
    chk("gap_pulse_end", {31'd0, abort_o}, 32'd0);

    // Symbol on the would-be timeout cycle keeps the frame alive.
    send_sync(SW);
    payload(0, 10, 1'b0, 16'd3);
    idle(7);
    payload(10, 11, 1'b0, 16'd3);
    settle();
    chk("gapsave_abort", {31'd0, abort_o}, 32'd0);
    chk("gapsave_locked", {31'd0, locked_o}, 32'd1);
    payload(11, PAY, 1'b0, 16'd3);

    // Back-to-back frames, first one carrying an embedded sync pattern.
    send_sync(SW);
    payload(0, PAY, 1'b1, 16'd4);
    send_sync(SW);
    payload(0, PAY, 1'b0, 16'd5);
    idle(2);
    chk("b2b_fcnt", {16'd0, frame_cnt_o}, 32'd5);

    // Mid-frame reset.
    send_sync(SW);
    payload(0, 100, 1'b0, 16'd6);
    pulse_reset();
    chk_zero("midreset");
    send_sync(SW);
    payload(0, PAY, 1'b0, 16'd1);
    idle(3);
    chk("final_fcnt", {16'd0, frame_cnt_o}, 32'd1);
    chk("queue_empty", q.size(), 32'd0);
    chk("abort_queue_empty", abq.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
